bigint_mult_seq: RTL and testbench

Parametrised sequential big-integer multiplier, successor to the fixed 256×256 multiplier in the crypto datapath. Operand width and digit size are parameters; one digit of the second operand is consumed per cycle through a single WIDTH×DIGIT multiply-accumulate. Adds a two's-complement signed mode and a busy indication. Sits between the modular-reduction stage and the operand register file.

---
 rtl/bigint_mult_seq_if.sv | 23 ++
 rtl/bigint_mult_seq.sv | 137 +++++++++++++
 tb/tb_bigint_mult_seq.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bigint_mult_seq_if.sv
// Handshake bundle for the sequential big-integer multiplier.
// Requester drives operands/start; the multiplier returns product, done, busy.
interface bigint_mult_seq_if #(
   parameter int WIDTH = 256
) ();
   logic               start;
   logic               signed_mode;
   logic [WIDTH-1:0]   in1;
   logic [WIDTH-1:0]   in2;
   logic [2*WIDTH-1:0] out;
   logic               done;
   logic               busy;

   modport master (
      output start, signed_mode, in1, in2,
      input  out, done, busy
   );

   modport slave (
      input  start, signed_mode, in1, in2,
      output out, done, busy
   );
endinterface

// File: rtl/bigint_mult_seq.sv
// Sequential WIDTH x WIDTH multiplier, one DIGIT-bit slice of the multiplier
// per cycle through a single WIDTH x DIGIT multiply-accumulate.
module bigint_mult_seq #(
   parameter int WIDTH = 256,
   parameter int DIGIT = 16
) (
   input  logic             clk,
   input  logic             reset,
   bigint_mult_seq_if.slave bus
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int W2   = 2 * WIDTH;
   localparam int WD   = WIDTH + DIGIT;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [W2-1:0]    out_q, out_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   logic [WIDTH-1:0] abs1, abs2;
   logic [WD-1:0]    prod, sum;
   logic [W2-1:0]    acc_sh;
   logic             last;

   // Operand magnitudes; the most negative value maps to 2^(W-1) exactly.
   always_comb begin
      abs1 = bus.in1;
      abs2 = bus.in2;
      if (bus.signed_mode) begin
         if (bus.in1[WIDTH-1]) abs1 = ~bus.in1 + 1'b1;
         if (bus.in2[WIDTH-1]) abs2 = ~bus.in2 + 1'b1;
      end
   end

   // One multiply-accumulate step on the upper half of the accumulator.
   always_comb begin
      prod = {{DIGIT{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q[DIGIT-1:0]};
      sum  = {{DIGIT{1'b0}}, acc_q[W2-1:WIDTH]} + prod;
   end

   // Shift the new partial sum down by one digit.
   if (DIGIT == WIDTH) begin : g_one
      assign acc_sh = sum;
   end else begin : g_multi
      assign acc_sh = {sum, acc_q[WIDTH-1:DIGIT]};
   end

   assign last = (cnt_q == CW'(NDIG - 1));

   // Control and datapath next-state.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               a_d     = abs1;
               b_d     = abs2;
               neg_d   = bus.signed_mode
                       & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
               acc_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = MUL;
            end
         end
         MUL: begin
            busy_d = 1'b1;
            acc_d  = acc_sh;
            b_d    = b_q >> DIGIT;
            cnt_d  = cnt_q + 1'b1;
            if (last) state_d = FIN;
         end
         FIN: begin
            busy_d  = 1'b1;
            out_d   = neg_q ? (~acc_q + 1'b1) : acc_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_bigint_mult_seq.sv
// Scoreboard bench for bigint_mult_seq at 256/16, 32/8 and 64/64.
// Expected products come from wide plain-arithmetic multiplication.
module tb_bigint_mult_seq;

   localparam int NM = 16;
   localparam int NS = 4;
   localparam int NW = 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bigint_mult_seq_if #(.WIDTH(256)) m_if ();
   bigint_mult_seq_if #(.WIDTH(32))  s_if ();
   bigint_mult_seq_if #(.WIDTH(64))  w_if ();

   bigint_mult_seq #(.WIDTH(256), .DIGIT(16)) u_m (
      .clk(clk), .reset(reset), .bus(m_if.slave));
   bigint_mult_seq #(.WIDTH(32), .DIGIT(8)) u_s (
      .clk(clk), .reset(reset), .bus(s_if.slave));
   bigint_mult_seq #(.WIDTH(64), .DIGIT(64)) u_w (
      .clk(clk), .reset(reset), .bus(w_if.slave));

   typedef struct {
      logic [511:0] p;
      longint       t;
   } exp_t;

   exp_t   q_m[$];
   exp_t   q_s[$];
   exp_t   q_w[$];
   int     total = 0;
   int     bad   = 0;
   longint cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Two's-complement or unsigned product of w-bit operands, mod 2^(2w).
   function automatic logic [511:0] ref_mul(
      input logic [255:0] a, input logic [255:0] b,
      input logic sm, input int w);
      logic [511:0] x, y;
      for (int i = 0; i < 512; i++) begin
         if (i < w) begin
            x[i] = a[i];
            y[i] = b[i];
         end else begin
            x[i] = sm & a[w-1];
            y[i] = sm & b[w-1];
         end
      end
      x = x * y;
      for (int i = 0; i < 512; i++) if (i >= 2 * w) x[i] = 1'b0;
      return x;
   endfunction

   function automatic logic [255:0] rnd_op(input int w);
      logic [255:0] v;
      int           sel;
      sel = $urandom_range(0, 9);
      v   = '0;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      case (sel)
         0: v = '0;
         1: v = '1;
         2: begin v = '0; v[w-1] = 1'b1; end
         3: begin v = '1; v[w-1] = 1'b0; end
         4: v = 256'd1;
         default: ;
      endcase
      for (int i = 0; i < 256; i++) if (i >= w) v[i] = 1'b0;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [511:0] act,
                      input logic [511:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, req);
      end
   endtask

   // Scoreboard monitors: one per multiplier instance.
   always @(negedge clk) begin
      exp_t e;
      if (m_if.done === 1'b1) begin
         if (q_m.size() == 0) begin
            chk("m_unexpected_done", 512'(m_if.done), 512'(0));
         end else begin
            e = q_m.pop_front();
            chk("m_out", m_if.out, e.p);
            chk("m_latency", 512'(cyc), 512'(e.t + NM + 2));
            chk("m_busy_at_done", 512'(m_if.busy), 512'(1));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (s_if.done === 1'b1) begin
         if (q_s.size() == 0) begin
            chk("s_unexpected_done", 512'(s_if.done), 512'(0));
         end else begin
            e = q_s.pop_front();
            chk("s_out", 512'(s_if.out), e.p);
            chk("s_latency", 512'(cyc), 512'(e.t + NS + 2));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (w_if.done === 1'b1) begin
         if (q_w.size() == 0) begin
            chk("w_unexpected_done", 512'(w_if.done), 512'(0));
         end else begin
            e = q_w.pop_front();
            chk("w_out", 512'(w_if.out), e.p);
            chk("w_latency", 512'(cyc), 512'(e.t + NW + 2));
         end
      end
   end

   // Present one request to the 256-bit unit; returns one cycle after E0.
   task automatic issue_m(input logic [255:0] a, input logic [255:0] b,
                          input logic sm);
      m_if.in1         = a;
      m_if.in2         = b;
      m_if.signed_mode = sm;
      m_if.start       = 1'b1;
      q_m.push_back('{p: ref_mul(a, b, sm, 256), t: cyc});
      @(negedge clk);
      m_if.start = 1'b0;
   endtask

   task automatic wait_done_m();
      int n;
      n = 0;
      while (m_if.done !== 1'b1 && n < NM + 8) begin
         @(negedge clk);
         n++;
      end
      if (m_if.done !== 1'b1)
         chk("m_timeout", 512'(m_if.done), 512'(1));
   endtask

   // Full transaction with per-cycle busy/done profile checks.
   task automatic run_m(input logic [255:0] a, input logic [255:0] b,
                        input logic sm);
      issue_m(a, b, sm);
      for (int m = 0; m <= NM + 2; m++) begin
         if (m > 0) @(negedge clk);
         chk("m_busy", 512'(m_if.busy), 512'(m <= NM + 1));
         chk("m_done", 512'(m_if.done), 512'(m == NM + 1));
      end
   endtask

   logic [255:0] ones, minv, a_r, b_r;
   logic [255:0] as_r, bs_r, aw_r, bw_r;
   logic         sm_r, sms_r, smw_r;
   logic [511:0] c_max;
   int           nws, nww;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ones = '1;
      minv = '0;
      minv[255] = 1'b1;
      m_if.start = 1'b0; m_if.signed_mode = 1'b0;
      m_if.in1 = '0; m_if.in2 = '0;
      s_if.start = 1'b0; s_if.signed_mode = 1'b0;
      s_if.in1 = '0; s_if.in2 = '0;
      w_if.start = 1'b0; w_if.signed_mode = 1'b0;
      w_if.in1 = '0; w_if.in2 = '0;

      // Reset with start held high: must stay idle.
      reset = 1'b1;
      m_if.start = 1'b1;
      m_if.in1 = 256'd3;
      m_if.in2 = 256'd4;
      repeat (3) @(negedge clk);
      chk("rst_out", m_if.out, 512'(0));
      chk("rst_done", 512'(m_if.done), 512'(0));
      chk("rst_busy", 512'(m_if.busy), 512'(0));
      reset = 1'b0;
      m_if.start = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", 512'(m_if.busy), 512'(0));

      // Unsigned maximum operands.
      run_m(ones, ones, 1'b0);
      c_max = {ones, 256'd1};
      c_max[256] = 1'b0;
      chk("umax_held", m_if.out, c_max);

      // Signed small and the same bits unsigned.
      run_m(ones, 256'd3, 1'b1);
      chk("s_m1x3", m_if.out, ~512'd2);
      run_m(ones, 256'd3, 1'b0);
      chk("u_ffx3", m_if.out, 512'(ones) * 512'd3);

      // Signed extremes.
      run_m(minv, minv, 1'b1);
      chk("min_x_min", m_if.out, 512'd1 << 510);
      run_m(minv, 256'd1, 1'b1);
      chk("min_x_1", m_if.out, {{257{1'b1}}, 255'd0});
      run_m(256'd0, minv, 1'b1);
      chk("zero_neg", m_if.out, 512'(0));

      // Starts while busy are ignored; start held in done cycle chains.
      issue_m(256'd5, 256'd7, 1'b0);
      for (int m = 1; m <= NM + 1; m++) begin
         @(negedge clk);
         m_if.in1         = 256'd9;
         m_if.signed_mode = (m == 2 || m == 15);
         m_if.start       = (m == 2 || m == 15 || m == NM + 1);
         if (m == NM + 1) begin
            m_if.in2 = 256'd5;
            q_m.push_back('{p: ref_mul(256'd9, 256'd5, 1'b0, 256),
                            t: cyc});
         end
      end
      chk("hs_first", m_if.out, 512'd35);
      @(negedge clk);
      m_if.start = 1'b0;
      wait_done_m();
      chk("hs_second", m_if.out, 512'd45);

      // Asynchronous reset mid-operation discards the product.
      @(negedge clk);
      issue_m(256'd11, 256'd13, 1'b0);
      repeat (7) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_out", m_if.out, 512'(0));
      chk("mid_rst_done", 512'(m_if.done), 512'(0));
      chk("mid_rst_busy", 512'(m_if.busy), 512'(0));
      q_m.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (NM + 4) @(negedge clk);
      chk("mid_rst_out_hold", m_if.out, 512'(0));

      // Randomised back-to-back traffic on all three instances.
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               a_r  = rnd_op(256);
               b_r  = rnd_op(256);
               sm_r = 1'(i & 1);
               issue_m(a_r, b_r, sm_r);
               wait_done_m();
            end
         end
         begin
            for (int i = 0; i < 2000; i++) begin
               as_r  = rnd_op(32);
               bs_r  = rnd_op(32);
               sms_r = (i >= 1000);
               s_if.in1         = as_r[31:0];
               s_if.in2         = bs_r[31:0];
               s_if.signed_mode = sms_r;
               s_if.start       = 1'b1;
               q_s.push_back('{p: ref_mul(as_r, bs_r, sms_r, 32), t: cyc});
               @(negedge clk);
               s_if.start = 1'b0;
               nws = 0;
               while (s_if.done !== 1'b1 && nws < NS + 8) begin
                  @(negedge clk);
                  nws++;
               end
               if (s_if.done !== 1'b1)
                  chk("s_timeout", 512'(s_if.done), 512'(1));
            end
         end
         begin
            for (int i = 0; i < 2000; i++) begin
               aw_r  = rnd_op(64);
               bw_r  = rnd_op(64);
               smw_r = (i >= 1000);
               w_if.in1         = aw_r[63:0];
               w_if.in2         = bw_r[63:0];
               w_if.signed_mode = smw_r;
               w_if.start       = 1'b1;
               q_w.push_back('{p: ref_mul(aw_r, bw_r, smw_r, 64), t: cyc});
               @(negedge clk);
               w_if.start = 1'b0;
               nww = 0;
               while (w_if.done !== 1'b1 && nww < NW + 8) begin
                  @(negedge clk);
                  nww++;
               end
               if (w_if.done !== 1'b1)
                  chk("w_timeout", 512'(w_if.done), 512'(1));
            end
         end
      join

      repeat (10) @(negedge clk);
      chk("m_drained", 512'(q_m.size()), 512'(0));
      chk("s_drained", 512'(q_s.size()), 512'(0));
      chk("w_drained", 512'(q_w.size()), 512'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
